vga_sync_decoder: RTL
=====================

Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA output path: consumes a VGA stream (Hsync, Vsync, 12-bit RGB) in the pixel-clock domain and recovers pixel coordinates, data-enable and lock status.
- Used for loopback self-check of the VGA generator and as a frame-capture front end.
- Hsync and Vsync are active-low, 640x480@60 timing by default.

Parameters:
- H_SYNC, 96, Hsync pulse width in clocks
- H_BACK, 48, horizontal back porch in clocks
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, clocks per line
- V_SYNC, 2, Vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- V_ACTIVE, 480, visible lines per frame
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
- clock  in  1  pixel clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low reset
- hsync_in  in  1  Hsync, active-low, synchronous to clock
- vsync_in  in  1  Vsync, active-low, synchronous to clock
- rgb_in  in  12  {R[3:0],G[3:0],B[3:0]}
- x  out  10  pixel column, 0..H_ACTIVE-1; 0 when de=0
- y  out  10  pixel row, 0..V_ACTIVE-1; 0 when de=0
- de  out  1  visible pixel valid (only while locked)
- rgb_out  out  12  rgb_in aligned to de; 0 when de=0
- line_start  out  1  1-cycle pulse on each detected Hsync falling edge
- frame_start  out  1  1-cycle pulse on the first line after a Vsync falling edge
- locked  out  1  timing lock achieved
- sync_err  out  1  1-cycle pulse when a bad line or frame is detected while in TRACK or LOCKED

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0; counters are 0; state is SEARCH; hs_d1, hs_d2, vs_d1 and vs_d2 are 1 (idle); vsync_pend is 0.
- Input stage: hsync_in, vsync_in and rgb_in are registered into hs_d1, vs_d1 and rgb_d1, then into hs_d2, vs_d2 and rgb_d2.
- Edge detection: hfall = hs_d2 & ~hs_d1; vfall = vs_d2 & ~vs_d1.
- h_cnt (11 bit):
  - On hfall: h_cnt <= 0, and h_period is latched as h_cnt+1.
  - Otherwise h_cnt increments, saturating at 2047.
- vsync_pend: set on vfall; cleared on the next hfall.
  - If vfall and hfall occur in the same cycle, that hfall consumes the pending Vsync.
- v_cnt (10 bit), updated on hfall:
  - If vsync_pend or vfall: v_cnt <= 0, frame_start pulses, and v_lines is latched as v_cnt+1.
  - Otherwise v_cnt increments, saturating at 1023.
- line_ok: h_period == H_TOTAL (checked at every hfall except the first after reset or after leaving SEARCH).
- frame_ok: v_lines == V_TOTAL, and every line in the frame was line_ok.
- State machine:
  - SEARCH: on the first frame boundary, clear good_cnt and go to TRACK.
  - TRACK:
    - Bad line or frame: sync_err, go to SEARCH.
    - Good frame boundary: good_cnt++; when good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED:
    - Bad line or frame: sync_err, locked<=0, go to SEARCH.
    - Timeout (h_cnt saturates or v_cnt saturates): same as a bad line or frame.
- Active region:
  - hact = h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE).
  - vact = v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
  - de = locked & hact & vact; x = h_cnt-(H_SYNC+H_BACK); y = v_cnt-(V_SYNC+V_BACK).
- Latency: x, y, de, rgb_out and line_start for the input sampled at clock edge k are registered outputs valid after edge k+2.
- locked asserts in the same cycle as the frame_start that completes the LOCK_FRAMES-th good frame, i.e. the first frame_start at which the lock condition is met.
- Reset mid-frame: immediate return to the reset state; the decoder re-searches from the next Vsync.

Test Plan:
- Nominal: drive 3 frames of 800x525 timing, with Hsync low for 96 clocks at line start and Vsync low for lines 0-1 → locked=1 at the 3rd frame_start (after LOCK_FRAMES=2 good frames have been counted); then de is high for exactly 640x480 cycles per frame, and the first de has x=0, y=0 at 2 clocks after the input at line 35, clock 144.
- Pixel alignment: rgb_in = {x[3:0],y[3:0],4'hA} → rgb_out matches the reported x and y on every de cycle; rgb_out=0 whenever de=0.
- Bad line while locked: shorten one line to 799 clocks → sync_err pulses once, locked=0, de stays low; lock is regained after 2 further good frames.
- Wrong frame length: 524-line frames → locked never asserts and sync_err pulses once per frame boundary in TRACK.
- Simultaneous Vsync and Hsync falling edges in the same cycle → v_cnt=0 and frame_start pulses on that hfall; there is no extra line and no second frame_start.
- Async reset asserted mid-line in LOCKED → all outputs go to 0 immediately without a clock edge; after release, locked returns after 2 good frames.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds pixel coordinates, data-enable and
// lock status from an incoming active-low Hsync/Vsync + 12-bit RGB stream.
module vga_sync_decoder #(
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic [11:0] rgb_out,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err
);

    localparam int unsigned H_START = H_SYNC + H_BACK;
    localparam int unsigned H_END   = H_START + H_ACTIVE;
    localparam int unsigned V_START = V_SYNC + V_BACK;
    localparam int unsigned V_END   = V_START + V_ACTIVE;
    localparam int unsigned GW      = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t        state;
    logic          hs_d1, hs_d2, vs_d1, vs_d2;
    logic [11:0]   rgb_d1, rgb_d2;
    logic [10:0]   h_cnt;
    logic [9:0]    v_cnt;
    logic          vsync_pend;
    logic          line_checked;
    logic [GW-1:0] good_cnt;
    logic          hfall_q, fs_q, err_q;

    logic          hfall, vfall, boundary;
    logic [11:0]   h_period;
    logic [10:0]   v_lines;
    logic          line_bad, frame_bad, timeout;
    logic          hact, vact, pix;

    // Length checks use the count at the closing edge directly, one bit wider
    // so a saturated counter can never alias to a legal length.
    always_comb begin
        hfall     = hs_d2 & ~hs_d1;
        vfall     = vs_d2 & ~vs_d1;
        boundary  = hfall & (vsync_pend | vfall);
        h_period  = {1'b0, h_cnt} + 12'd1;
        v_lines   = {1'b0, v_cnt} + 11'd1;
        line_bad  = hfall & line_checked & (h_period != 12'(H_TOTAL));
        frame_bad = boundary & (v_lines != 11'(V_TOTAL));
        timeout   = ~hfall & ((h_cnt == '1) | (v_cnt == '1));
        hact      = (h_cnt >= 11'(H_START)) & (h_cnt < 11'(H_END));
        vact      = (v_cnt >= 10'(V_START)) & (v_cnt < 10'(V_END));
        pix       = (state == LOCKED) & hact & vact;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= SEARCH;
            hs_d1        <= 1'b1;
            hs_d2        <= 1'b1;
            vs_d1        <= 1'b1;
            vs_d2        <= 1'b1;
            rgb_d1       <= '0;
            rgb_d2       <= '0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            vsync_pend   <= 1'b0;
            line_checked <= 1'b0;
            good_cnt     <= '0;
            hfall_q      <= 1'b0;
            fs_q         <= 1'b0;
            err_q        <= 1'b0;
            x            <= '0;
            y            <= '0;
            de           <= 1'b0;
            rgb_out      <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            locked       <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            hs_d1  <= hsync_in;
            hs_d2  <= hs_d1;
            vs_d1  <= vsync_in;
            vs_d2  <= vs_d1;
            rgb_d1 <= rgb_in;
            rgb_d2 <= rgb_d1;

            if (hfall)
                h_cnt <= '0;
            else if (h_cnt != '1)
                h_cnt <= h_cnt + 11'd1;

            // An hfall in the same cycle as vfall consumes it immediately.
            if (hfall)
                vsync_pend <= 1'b0;
            else if (vfall)
                vsync_pend <= 1'b1;

            if (boundary)
                v_cnt <= '0;
            else if (hfall && v_cnt != '1)
                v_cnt <= v_cnt + 10'd1;

            if (hfall)
                line_checked <= 1'b1;

            hfall_q <= hfall;
            fs_q    <= boundary;
            err_q   <= 1'b0;

            case (state)
                SEARCH: begin
                    if (boundary) begin
                        good_cnt     <= '0;
                        line_checked <= 1'b0;
                        state        <= TRACK;
                    end
                end
                TRACK: begin
                    if (line_bad || frame_bad) begin
                        err_q <= 1'b1;
                        state <= SEARCH;
                    end else if (boundary) begin
                        good_cnt <= good_cnt + 1'b1;
                        if (good_cnt == GW'(LOCK_FRAMES - 1))
                            state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (line_bad || frame_bad || timeout) begin
                        err_q <= 1'b1;
                        state <= SEARCH;
                    end
                end
                default: state <= SEARCH;
            endcase

            // Output stage: aligned two edges after the sampled input.
            line_start  <= hfall_q;
            frame_start <= fs_q;
            sync_err    <= err_q;
            locked      <= (state == LOCKED);
            de          <= pix;
            x           <= pix ? 10'(h_cnt - 11'(H_START)) : '0;
            y           <= pix ? (v_cnt - 10'(V_START)) : '0;
            rgb_out     <= pix ? rgb_d2 : '0;
        end
    end

endmodule
